// File: rtl/yarp_dmem_responder.sv
// ---------------------------------------------------------------------------
// yarp_dmem_responder
//
// Single-port data memory with a request/response handshake toward the
// core-side data memory unit. Each request is taken in IDLE, optionally waits
// WAIT_CYCLES cycles, performs the access in ACCESS, and reports completion in
// RESP with a one-cycle mem_rvalid_o strobe. Only one access is in flight at
// a time.
//
// Optional feature macro:
//   YARP_DMEM_ALIGN_CHECK_EN - flag misaligned, reserved-size and out-of-range
//                              accesses on mem_err_o and suppress their effect.
//                              When undefined, mem_err_o is tied 0 and the
//                              address is wrapped and aligned silently.
//
// Parameters:
//   DEPTH        memory size in 32-bit words (power of 2, >= 2)
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports:
//   clk            in   clock, all state on the rising edge
//   reset          in   asynchronous active-high reset
//   mem_req_i      in   access request (sampled only while idle)
//   mem_addr_i     in   byte address
//   mem_byte_en_i  in   size: 00 byte, 01 half, 11 word, 10 reserved
//   mem_wr_i       in   1 = write, 0 = read
//   mem_wr_data_i  in   low-aligned write data
//   mem_ready_o    out  responder idle; a request is accepted this cycle
//   mem_rvalid_o   out  one-cycle completion strobe
//   mem_rd_data_o  out  low-aligned, zero-filled read data
//   mem_err_o      out  access error, valid with mem_rvalid_o
// ---------------------------------------------------------------------------
module yarp_dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic [1:0]  mem_byte_en_i,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_wr_data_i,
  output logic        mem_ready_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_err_o
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;

  // Captured request
  logic [31:0] addr_q;
  logic [1:0]  byte_en_q;
  logic        wr_q;
  logic [31:0] wr_data_q;

  // Response registers, updated only at the ACCESS exit edge
  logic [31:0] rd_data_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          commit;
  logic          is_byte;
  logic          is_half;
  logic [AW-1:0] word_idx;
  logic          acc_err;
  logic [3:0]    lane_en;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_ext;

  assign accept   = (state == ST_IDLE) && mem_req_i;
  assign commit   = (state == ST_ACCESS);
  assign is_byte  = (byte_en_q == 2'b00);
  assign is_half  = (byte_en_q == 2'b01);
  assign word_idx = addr_q[AW+1:2];

`ifdef YARP_DMEM_ALIGN_CHECK_EN
  assign acc_err = (is_half && addr_q[0])
                || ((byte_en_q == 2'b11) && (addr_q[1:0] != 2'b00))
                || (byte_en_q == 2'b10)
                || ((addr_q >> (AW + 2)) != 32'd0);
`else
  // Reserved size falls through to word handling; high address bits wrap.
  assign acc_err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{addr_q[31:AW+2], err_q};
`endif

  // Replicate write data across lanes so the lane enable alone picks the target.
  always_comb begin
    lane_en = 4'b1111;
    wr_word = wr_data_q;
    if (is_byte) begin
      lane_en = 4'b0001 << addr_q[1:0];
      wr_word = {4{wr_data_q[7:0]}};
    end else if (is_half) begin
      lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      wr_word = {2{wr_data_q[15:0]}};
    end
  end

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};

  always_comb begin
    rd_ext = rd_word;
    if (is_byte) begin
      rd_ext = {24'b0, rd_shift[7:0]};
    end else if (is_half) begin
      rd_ext = addr_q[1] ? {16'b0, rd_word[31:16]} : {16'b0, rd_word[15:0]};
    end
  end

  // NOTE: the storage array has no reset; clearing thousands of words would
  // force it into flops. The reset term only blocks a write racing reset.
  always_ff @(posedge clk) begin
    if (!reset && commit && wr_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first so no path leaves state_next unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (mem_req_i) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (wait_cnt == 4'd0) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_ready_o   = (state == ST_IDLE);
    mem_rvalid_o  = (state == ST_RESP);
    mem_rd_data_o = rd_data_q;
`ifdef YARP_DMEM_ALIGN_CHECK_EN
    mem_err_o     = err_q;
`else
    mem_err_o     = 1'b0;
`endif
  end

  // Request capture, wait counter and response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      addr_q    <= 32'd0;
      byte_en_q <= 2'b00;
      wr_q      <= 1'b0;
      wr_data_q <= 32'd0;
      rd_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= mem_addr_i;
        byte_en_q <= mem_byte_en_i;
        wr_q      <= mem_wr_i;
        wr_data_q <= mem_wr_data_i;
        wait_cnt  <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (commit) begin
        err_q     <= acc_err;
        rd_data_q <= (wr_q || acc_err) ? 32'd0 : rd_ext;
      end
    end
  end

endmodule

// File: tb/tb_yarp_dmem_responder.sv
module tb_yarp_dmem_responder;

`ifdef YARP_DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: WAIT_CYCLES=0, small DEPTH so wrap/range is reachable
  logic        rst0, req0, wr0, ready0, rvalid0, err0;
  logic [31:0] addr0, wd0, rd0;
  logic [1:0]  be0;
  // dut3: WAIT_CYCLES=3
  logic        rst3, req3, wr3, ready3, rvalid3, err3;
  logic [31:0] addr3, wd3, rd3;
  logic [1:0]  be3;

  yarp_dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst0), .mem_req_i(req0), .mem_addr_i(addr0),
    .mem_byte_en_i(be0), .mem_wr_i(wr0), .mem_wr_data_i(wd0),
    .mem_ready_o(ready0), .mem_rvalid_o(rvalid0), .mem_rd_data_o(rd0),
    .mem_err_o(err0));

  yarp_dmem_responder #(.DEPTH(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(rst3), .mem_req_i(req3), .mem_addr_i(addr3),
    .mem_byte_en_i(be3), .mem_wr_i(wr3), .mem_wr_data_i(wd3),
    .mem_ready_o(ready3), .mem_rvalid_o(rvalid3), .mem_rd_data_o(rd3),
    .mem_err_o(err3));

  typedef struct {
    logic        wr;
    logic [1:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          idx;
  } exp_t;

  vec_t tbl[21];
  exp_t sb[$];
  int   rv_count0 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer for dut0: data, error flag and arrival cycle.
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      rv_count0++;
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("resp_v%0d", e.idx), {31'b0, err0, rd0}, {31'b0, e.err, e.data});
        check($sformatf("lat_v%0d", e.idx), 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic acc0(input int i);
    int n = 0;
    while (ready0 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check($sformatf("ready_v%0d", i), 64'(ready0), 64'd1);
    req0 = 1'b1; wr0 = tbl[i].wr; be0 = tbl[i].be; addr0 = tbl[i].addr; wd0 = tbl[i].wd;
    sb.push_back('{tbl[i].exp_rd, tbl[i].exp_err, cyc + 2, i});
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  task automatic drain0();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  // One dut3 access with cycle-exact ready/rvalid checking after accept.
  task automatic acc3(input string tag, input logic wr, input logic [1:0] be,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n = 0;
    while (ready3 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "_ready_in"}, 64'(ready3), 64'd1);
    req3 = 1'b1; wr3 = wr; be3 = be; addr3 = addr; wd3 = wd;
    @(posedge clk); #1;
    req3 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("%s_ready_c%0d", tag, k), 64'(ready3), 64'(k == 6));
      check($sformatf("%s_rvalid_c%0d", tag, k), 64'(rvalid3), 64'(k == 5));
      if (k == 5) check({tag, "_data"}, {31'b0, err3, rd3}, {31'b0, exp_err, exp_rd});
      @(posedge clk); #1;
    end
  endtask

  // Start a byte write of 0x55 @0x20 on dut3, hit reset after `delay` cycles.
  task automatic reset_abort3(input string tag, input int delay);
    int seen = 0;
    req3 = 1'b1; wr3 = 1'b1; be3 = 2'b00; addr3 = 32'h20; wd3 = 32'h55;
    @(posedge clk); #1;
    req3 = 1'b0;
    for (int k = 1; k < delay; k++) begin @(posedge clk); #1; end
    rst3 = 1'b1;
    #1;
    check({tag, "_rst_ready"}, 64'(ready3), 64'd1);
    check({tag, "_rst_rvalid"}, 64'(rvalid3), 64'd0);
    check({tag, "_rst_rd"}, 64'(rd3), 64'd0);
    check({tag, "_rst_err"}, 64'(err3), 64'd0);
    @(posedge clk); #1;
    rst3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rvalid3 === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check({tag, "_no_rvalid"}, 64'(seen), 64'd0);
    check({tag, "_ready_after"}, 64'(ready3), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rv_before;
    int accepts;
    int acc_cyc[$];

    tbl[0]  = '{1'b1, 2'b11, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 2'b11, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'b00, 32'h13,  32'h000000A5, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 2'b11, 32'h10,  32'h0,        32'hA5ADBEEF, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 32'h13,  32'h0,        32'h000000A5, 1'b0};
    tbl[5]  = '{1'b0, 2'b01, 32'h12,  32'h0,        32'h0000A5AD, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 32'h11,  32'h0,        32'h000000BE, 1'b0};
    tbl[7]  = '{1'b1, 2'b01, 32'h11,  32'h00001234, 32'h0,        ALIGN};
    tbl[8]  = '{1'b0, 2'b11, 32'h10,  32'h0,        ALIGN ? 32'hA5ADBEEF : 32'hA5AD1234, 1'b0};
    tbl[9]  = '{1'b1, 2'b11, 32'h20,  32'h11223344, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 2'b11, 32'h22,  32'h0,        ALIGN ? 32'h0 : 32'h11223344, ALIGN};
    tbl[11] = '{1'b0, 2'b10, 32'h20,  32'h0,        ALIGN ? 32'h0 : 32'h11223344, ALIGN};
    tbl[12] = '{1'b1, 2'b11, 32'h120, 32'hCAFEF00D, 32'h0,        ALIGN};
    tbl[13] = '{1'b0, 2'b11, 32'h20,  32'h0,        ALIGN ? 32'h11223344 : 32'hCAFEF00D, 1'b0};
    tbl[14] = '{1'b1, 2'b01, 32'h22,  32'hFFFFBEEF, 32'h0,        1'b0};
    tbl[15] = '{1'b0, 2'b01, 32'h22,  32'h0,        32'h0000BEEF, 1'b0};
    tbl[16] = '{1'b1, 2'b00, 32'h21,  32'h12345678, 32'h0,        1'b0};
    tbl[17] = '{1'b0, 2'b11, 32'h20,  32'h0,        ALIGN ? 32'hBEEF7844 : 32'hBEEF780D, 1'b0};
    tbl[18] = '{1'b0, 2'b00, 32'h21,  32'h0,        32'h00000078, 1'b0};
    tbl[19] = '{1'b0, 2'b11, 32'h110, 32'h0,        ALIGN ? 32'h0 : 32'hA5AD1234, ALIGN};
    tbl[20] = '{1'b0, 2'b01, 32'h20,  32'h0,        ALIGN ? 32'h00007844 : 32'h0000780D, 1'b0};

    rst0 = 1'b1; req0 = 1'b0; wr0 = 1'b0; be0 = 2'b00; addr0 = '0; wd0 = '0;
    rst3 = 1'b1; req3 = 1'b0; wr3 = 1'b0; be3 = 2'b00; addr3 = '0; wd3 = '0;

    @(posedge clk); #1;
    @(negedge clk);
    check("rst0_ready",  64'(ready0),  64'd1);
    check("rst0_rvalid", 64'(rvalid0), 64'd0);
    check("rst0_rd",     64'(rd0),     64'd0);
    check("rst0_err",    64'(err0),    64'd0);
    check("rst3_ready",  64'(ready3),  64'd1);
    check("rst3_rvalid", 64'(rvalid3), 64'd0);
    check("rst3_rd",     64'(rd3),     64'd0);
    check("rst3_err",    64'(err3),    64'd0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(posedge clk); #1;

    // Table-driven accesses on the zero-wait instance
    for (int i = 0; i < 21; i++) acc0(i);
    drain0();

    // Read data holds its last value while idle
    repeat (3) begin @(posedge clk); #1; end
    check("rd_hold", 64'(rd0), 64'(tbl[20].exp_rd));

    // Request held high for 9 cycles: one accept every 3 cycles
    rv_before = rv_count0;
    accepts   = 0;
    req0 = 1'b1; wr0 = 1'b0; be0 = 2'b11; addr0 = 32'h20; wd0 = '0;
    for (int k = 0; k < 9; k++) begin
      if (ready0 === 1'b1) begin
        accepts++;
        acc_cyc.push_back(cyc);
        sb.push_back('{tbl[17].exp_rd, 1'b0, cyc + 2, 100 + k});
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0;
    drain0();
    repeat (2) begin @(posedge clk); #1; end
    check("burst_accepts", 64'(accepts), 64'd3);
    check("burst_rvalids", 64'(rv_count0 - rv_before), 64'd3);
    if (acc_cyc.size() == 3) begin
      check("burst_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
      check("burst_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
    end

    // Wait-state instance: timing, then reset during WAIT and during ACCESS
    acc3("w3a", 1'b1, 2'b11, 32'h20, 32'h0BADCAFE, 32'h0, 1'b0);
    acc3("r3a", 1'b0, 2'b11, 32'h20, 32'h0,        32'h0BADCAFE, 1'b0);
    reset_abort3("abort_wait", 2);
    acc3("r3b", 1'b0, 2'b11, 32'h20, 32'h0,        32'h0BADCAFE, 1'b0);
    reset_abort3("abort_access", 4);
    acc3("r3c", 1'b0, 2'b11, 32'h20, 32'h0,        32'h0BADCAFE, 1'b0);
    acc3("r3d", 1'b0, 2'b00, 32'h22, 32'h0,        32'h000000AD, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
